// File: rtl/mha_pkg.sv
// mha_pkg: shared state encoding, default widths and clog2 for the MHA dot-product stage.
package mha_pkg;

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_REQ = 2'd1,
        S_OUT = 2'd2
    } state_t;

    localparam int IN_W_DEF  = 30;
    localparam int OUT_W_DEF = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/acc_requant.sv
// acc_requant: combinational right shift plus saturation of a dot-product sum.
// Macro ACC_ROUND_EN adds round-half-up before the shift.
module acc_requant #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [4:0]       shift,
    output logic             sat,
    output logic [OUT_W-1:0] data
);

    logic [ACC_W:0] sum;
    logic [ACC_W:0] r;

`ifdef ACC_ROUND_EN
    // Extra top bit keeps the rounding carry of a full accumulator.
    assign sum = {1'b0, acc} + ((shift == 5'd0) ? '0 : ((ACC_W+1)'(1) << (shift - 5'd1)));
`else
    assign sum = {1'b0, acc};
`endif

    assign r    = sum >> shift;
    assign sat  = |r[ACC_W:OUT_W];
    assign data = sat ? '1 : r[OUT_W-1:0];

endmodule

// File: rtl/dot_accum_requant.sv
// dot_accum_requant: accumulates VEC_LEN products, requantizes, and hands off via valid/ready.
// Macro ACC_ROUND_EN (in acc_requant) selects rounding instead of truncation.
module dot_accum_requant
    import mha_pkg::*;
#(
    parameter int VEC_LEN = 4,
    parameter int IN_W    = IN_W_DEF,
    parameter int OUT_W   = OUT_W_DEF
) (
    input  logic             I_CLK,
    input  logic             I_RST_N,
    input  logic [IN_W-1:0]  I_PROD,
    input  logic             I_VALID,
    output logic             O_READY,
    input  logic [4:0]       I_SHIFT,
    output logic [OUT_W-1:0] O_DATA,
    output logic             O_VALID,
    input  logic             I_READY,
    output logic             O_SAT
);

    localparam int ACC_W = IN_W + clog2(VEC_LEN);
    localparam int CNT_W = clog2(VEC_LEN);

    state_t state, state_n;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             take, last, rq_sat;
    logic [OUT_W-1:0] rq_data;

    assign O_READY = (state == S_ACC);
    assign take    = I_VALID && O_READY;
    assign last    = (cnt == CNT_W'(VEC_LEN - 1));

    acc_requant #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_rq (
        .acc   (acc),
        .shift (I_SHIFT),
        .sat   (rq_sat),
        .data  (rq_data)
    );

    always_comb begin
        state_n = state;
        state_n = (state == S_ACC && take && last) ? S_REQ :
                  (state == S_REQ)                 ? S_OUT :
                  (state == S_OUT && I_READY)      ? S_ACC : state;
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state   <= S_ACC;
            acc     <= '0;
            cnt     <= '0;
            O_DATA  <= '0;
            O_VALID <= 1'b0;
            O_SAT   <= 1'b0;
        end else begin
            state <= state_n;
            if (take) begin
                acc <= acc + ACC_W'(I_PROD);
                cnt <= cnt + CNT_W'(1);
            end
            if (state == S_REQ) begin
                O_DATA  <= rq_data;
                O_SAT   <= rq_sat;
                O_VALID <= 1'b1;
            end
            // Clearing here also covers VEC_LEN that is not a power of two.
            if (state == S_OUT && I_READY) begin
                O_VALID <= 1'b0;
                acc     <= '0;
                cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dot_accum_requant.sv
// tb_dot_accum_requant: directed and random vectors against an arithmetic reference model.
module tb_dot_accum_requant;

    logic        clk = 1'b0;
    logic        I_RST_N;
    logic [29:0] I_PROD;
    logic        I_VALID;
    logic        O_READY;
    logic [4:0]  I_SHIFT;
    logic [15:0] O_DATA;
    logic        O_VALID;
    logic        I_READY;
    logic        O_SAT;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_accum_requant #(.VEC_LEN(4), .IN_W(30), .OUT_W(16)) dut (
        .I_CLK   (clk),
        .I_RST_N (I_RST_N),
        .I_PROD  (I_PROD),
        .I_VALID (I_VALID),
        .O_READY (O_READY),
        .I_SHIFT (I_SHIFT),
        .O_DATA  (O_DATA),
        .O_VALID (O_VALID),
        .I_READY (I_READY),
        .O_SAT   (O_SAT)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer sum, shift (optionally rounded), clip to 16 bits.
    function automatic logic [16:0] model(input longint b[4], input int sh);
        longint s, r;
        s = 0;
        foreach (b[i]) s += b[i];
`ifdef ACC_ROUND_EN
        r = (sh == 0) ? s : (s + (longint'(1) << (sh - 1))) >> sh;
`else
        r = s >> sh;
`endif
        return (r > 65535) ? {1'b1, 16'hFFFF} : {1'b0, r[15:0]};
    endfunction

    task automatic run_vec(input longint b[4], input int sh, input bit bub, input int stall,
                           input string tag);
        logic [16:0] e;
        e = model(b, sh);
        I_SHIFT = 5'(sh);
        I_READY = (stall == 0);
        for (int i = 0; i < 4; i++) begin
            if (bub) begin
                I_VALID = 1'b0;
                I_PROD  = 30'($urandom);
                @(negedge clk);
            end
            chk({tag, "_acc_rdy"}, O_READY, 1);
            I_VALID = 1'b1;
            I_PROD  = 30'(b[i]);
            @(negedge clk);
        end
        I_VALID = 1'b0;
        chk({tag, "_req_valid"}, O_VALID, 0);
        chk({tag, "_req_rdy"}, O_READY, 0);
        @(negedge clk);
        chk({tag, "_valid"}, O_VALID, 1);
        chk({tag, "_data"}, O_DATA, e[15:0]);
        chk({tag, "_sat"}, O_SAT, e[16]);
        if (stall > 0) begin
            I_VALID = 1'b1;
            I_PROD  = 30'($urandom);
            repeat (stall) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, O_VALID, 1);
                chk({tag, "_hold_data"}, O_DATA, e[15:0]);
                chk({tag, "_hold_sat"}, O_SAT, e[16]);
                chk({tag, "_hold_rdy"}, O_READY, 0);
            end
            I_VALID = 1'b0;
            I_READY = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_done_valid"}, O_VALID, 0);
        chk({tag, "_done_rdy"}, O_READY, 1);
    endtask

    initial begin
        longint rb[4];
        I_RST_N = 1'b0;
        I_PROD  = '0;
        I_VALID = 1'b0;
        I_SHIFT = '0;
        I_READY = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_data", O_DATA, 0);
        chk("rst_valid", O_VALID, 0);
        chk("rst_sat", O_SAT, 0);
        chk("rst_rdy", O_READY, 1);
        I_RST_N = 1'b1;
        @(negedge clk);

        run_vec('{10, 20, 30, 40}, 0, 1'b0, 0, "t1_sum");
        run_vec('{7, 0, 0, 0}, 2, 1'b0, 0, "t2_shift");
        run_vec('{30'h3FFFFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF}, 0, 1'b0, 0, "t3_sat");
        run_vec('{1000, 2000, 3000, 4000}, 1, 1'b0, 5, "t4_stall");

        // Partial vector discarded by reset; O_DATA still holds the t4 result here.
        I_VALID = 1'b1;
        I_PROD  = 30'd99;
        repeat (2) @(negedge clk);
        I_VALID = 1'b0;
        I_RST_N = 1'b0;
        #1;
        chk("t5_rst_data", O_DATA, 0);
        chk("t5_rst_valid", O_VALID, 0);
        chk("t5_rst_sat", O_SAT, 0);
        chk("t5_rst_rdy", O_READY, 1);
        @(negedge clk);
        I_RST_N = 1'b1;
        @(negedge clk);
        run_vec('{1, 2, 3, 4}, 0, 1'b0, 0, "t5_after");

        run_vec('{5, 5, 5, 5}, 0, 1'b1, 0, "t6_bubble");
        repeat (3) @(negedge clk);
        chk("t6_single_result", O_VALID, 0);

        run_vec('{30'h3FFFFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF}, 31, 1'b0, 0, "big_shift");
        run_vec('{30'h3FFFFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF}, 16, 1'b0, 0, "edge16");

        for (int n = 0; n < 24; n++) begin
            foreach (rb[i]) rb[i] = longint'($urandom) & 64'h3FFFFFFF;
            run_vec(rb, int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
